// File: rtl/step_cnt_scheduler_if.sv
// CPU preset-write request channel and readout stream between the scheduler and its clients.
interface step_cnt_scheduler_if #(
  parameter int AX_W = 2
);
  logic            wr_req;
  logic [AX_W-1:0] wr_axis;
  logic            wr_addr;
  logic [1:0]      wr_be;
  logic [15:0]     wr_data;
  logic            wr_ack;

  logic            rd_valid;
  logic            rd_ready;
  logic [31:0]     rd_data;
  logic [AX_W-1:0] rd_axis;
  logic            rd_sel;
  logic            rd_last;

  modport master (
    output wr_req, wr_axis, wr_addr, wr_be, wr_data,
    input  wr_ack,
    input  rd_valid, rd_data, rd_axis, rd_sel, rd_last,
    output rd_ready
  );

  modport slave (
    input  wr_req, wr_axis, wr_addr, wr_be, wr_data,
    output wr_ack,
    output rd_valid, rd_data, rd_axis, rd_sel, rd_last,
    input  rd_ready
  );
endinterface

// File: rtl/step_cnt_scheduler.sv
// Snapshot sequencer, readout serialiser and preset-write arbiter for AXES step counter channels.
// Optional feature: define SNAP_TIMESTAMP_EN to append a 32-bit cycle timestamp word to every frame.
module step_cnt_scheduler #(
  parameter int AXES     = 4,
  parameter int PERIOD_W = 16,
  parameter int AX_W     = (AXES > 1) ? $clog2(AXES) : 1
) (
  input  logic                clk,
  input  logic                aclr_n,
  input  logic                sclr,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic [AXES-1:0]     step_busy,
  output logic [AXES-1:0]     cnt_write,
  output logic                cnt_addr,
  output logic [1:0]          cnt_be,
  output logic [15:0]         cnt_wrdata,
  output logic                snapshot,
  input  logic [32*AXES-1:0]  cnt_in,
  input  logic [32*AXES-1:0]  delta_in,
  output logic                overrun,
  step_cnt_scheduler_if.slave bus
);
`ifdef SNAP_TIMESTAMP_EN
  localparam int NWORDS = 2 * AXES + 1;
`else
  localparam int NWORDS = 2 * AXES;
`endif
  localparam int IDX_W = $clog2(NWORDS);
  localparam int AXN   = 2 ** AX_W;

  typedef enum logic [1:0] {IDLE, SNAP, SETTLE, SEND} state_t;

  state_t                state;
  logic [PERIOD_W-1:0]   pcnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      nidx;
  logic [32*NWORDS-1:0]  frame;
  logic                  tick;
  logic                  grant;
  logic                  wr_done;
  logic                  ack;
  logic [AXN-1:0]        busy_ext;
  logic [AXN-1:0]        wr_onehot;
  logic                  rd_valid;
  logic [31:0]           rd_data;
  logic [AX_W-1:0]       rd_axis;
  logic                  rd_sel;
  logic                  rd_last;

  // Word i carries axis i/2, type i[0]; the optional timestamp word reports axis 0, type 1.
  function automatic logic [AX_W-1:0] word_axis(input logic [IDX_W-1:0] i);
    return (int'(i) >= 2 * AXES) ? AX_W'(0) : AX_W'(i >> 1);
  endfunction

  function automatic logic word_sel(input logic [IDX_W-1:0] i);
    return (int'(i) >= 2 * AXES) ? 1'b1 : i[0];
  endfunction

  assign tick      = run && (pcnt == period);
  assign nidx      = idx + 1'b1;
  assign busy_ext  = AXN'(step_busy);
  assign wr_onehot = AXN'(1) << bus.wr_axis;
  // Ticks take priority: no grant while a snapshot is imminent or being settled.
  assign grant = bus.wr_req && !wr_done && !busy_ext[bus.wr_axis] &&
                 ((state == IDLE && !tick) || state == SEND);

  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.rd_axis  = rd_axis;
  assign bus.rd_sel   = rd_sel;
  assign bus.rd_last  = rd_last;
  assign bus.wr_ack   = ack;

`ifdef SNAP_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)   ts <= '0;
    else if (sclr) ts <= '0;
    else           ts <= ts + 1'b1;
  end
`endif

  // Frame buffer: channels have updated on the snapshot edge by the end of SETTLE.
  always_ff @(posedge clk) begin
    if (state == SETTLE) begin
      for (int a = 0; a < AXES; a++) begin
        frame[64*a +: 32]      <= cnt_in[32*a +: 32];
        frame[64*a + 32 +: 32] <= delta_in[32*a +: 32];
      end
    end
`ifdef SNAP_TIMESTAMP_EN
    if (state == SNAP) frame[64*AXES +: 32] <= ts;
`endif
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE; pcnt <= '0; idx <= '0; snapshot <= 1'b0; overrun <= 1'b0;
      rd_valid <= 1'b0; rd_data <= '0; rd_axis <= '0; rd_sel <= 1'b0; rd_last <= 1'b0;
    end else if (sclr) begin
      state <= IDLE; pcnt <= '0; idx <= '0; snapshot <= 1'b0; overrun <= 1'b0;
      rd_valid <= 1'b0; rd_data <= '0; rd_axis <= '0; rd_sel <= 1'b0; rd_last <= 1'b0;
    end else begin
      pcnt     <= (!run || tick) ? '0 : pcnt + 1'b1;
      snapshot <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state    <= SNAP;
          snapshot <= 1'b1;
        end
        SNAP: state <= SETTLE;
        SETTLE: begin
          state    <= SEND;
          idx      <= '0;
          rd_valid <= 1'b1;
          rd_data  <= cnt_in[31:0];
          rd_axis  <= '0;
          rd_sel   <= 1'b0;
          rd_last  <= 1'b0;
        end
        SEND: if (rd_valid && bus.rd_ready) begin
          if (rd_last) begin
            state <= IDLE; idx <= '0;
            rd_valid <= 1'b0; rd_data <= '0; rd_axis <= '0; rd_sel <= 1'b0; rd_last <= 1'b0;
          end else begin
            idx     <= nidx;
            rd_data <= frame[32*int'(nidx) +: 32];
            rd_axis <= word_axis(nidx);
            rd_sel  <= word_sel(nidx);
            rd_last <= (nidx == IDX_W'(NWORDS - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // wr_done blocks a second grant while the same request is still held after its ack.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ack <= 1'b0; wr_done <= 1'b0; cnt_write <= '0;
      cnt_addr <= 1'b0; cnt_be <= '0; cnt_wrdata <= '0;
    end else if (sclr) begin
      ack <= 1'b0; wr_done <= 1'b0; cnt_write <= '0;
      cnt_addr <= 1'b0; cnt_be <= '0; cnt_wrdata <= '0;
    end else begin
      ack       <= grant;
      cnt_write <= (grant && |bus.wr_be) ? AXES'(wr_onehot) : '0;
      if (grant) begin
        cnt_addr   <= bus.wr_addr;
        cnt_be     <= bus.wr_be;
        cnt_wrdata <= bus.wr_data;
      end
      if (grant)            wr_done <= 1'b1;
      else if (!bus.wr_req) wr_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_step_cnt_scheduler.sv
// Self-checking bench for step_cnt_scheduler: frame scoreboard, write-arbitration vector table, reset corners.
`timescale 1ns/1ps
module tb_step_cnt_scheduler;
  localparam int AXES = 4;
  localparam int PERIOD_W = 16;
  localparam int AX_W = 2;
`ifdef SNAP_TIMESTAMP_EN
  localparam int NW = 2 * AXES + 1;
  localparam int P1 = 49;
`else
  localparam int NW = 2 * AXES;
  localparam int P1 = 99;
`endif

  logic clk = 1'b0;
  logic aclr_n, sclr, run;
  logic [PERIOD_W-1:0] period;
  logic [AXES-1:0] step_busy, cnt_write;
  logic cnt_addr, snapshot, overrun;
  logic [1:0] cnt_be;
  logic [15:0] cnt_wrdata;
  logic [32*AXES-1:0] cnt_in, delta_in;

  step_cnt_scheduler_if #(.AX_W(AX_W)) bus();

  step_cnt_scheduler #(.AXES(AXES), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .run(run), .period(period),
    .step_busy(step_busy), .cnt_write(cnt_write), .cnt_addr(cnt_addr), .cnt_be(cnt_be),
    .cnt_wrdata(cnt_wrdata), .snapshot(snapshot), .cnt_in(cnt_in), .delta_in(delta_in),
    .overrun(overrun), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic [AX_W-1:0] axis;
    logic            sel;
    logic            last;
  } word_t;

  typedef struct {
    logic [AX_W-1:0] axis;
    logic            addr;
    logic [1:0]      be;
    logic [15:0]     data;
    logic [3:0]      busy;
    logic [3:0]      exp_write;
  } wvec_t;

  word_t sb[$];
  wvec_t vec[5];
  int nchk = 0, nerr = 0;
  int cycle = 0, last_snap = -1, intv_exp = 0, widx = 0, frames_done = 0, pops = 0;
  bit intv_en = 0, settle_flag = 0, hold_vld = 0;
  logic [35:0] hold_word;
`ifdef SNAP_TIMESTAMP_EN
  logic [31:0] ts_model = '0;
  logic [31:0] snap_ts = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.rd_valid, bus.rd_last, bus.rd_sel, bus.rd_axis, bus.rd_data, snapshot, bus.wr_ack,
            cnt_write, cnt_addr, cnt_be, cnt_wrdata, overrun};
  endfunction

  // One clock cycle: inputs for this cycle are already set; monitor, then advance to the next negedge.
  task automatic cyc();
    word_t w;
    if (settle_flag) begin
      for (int a = 0; a < AXES; a++) begin
        cnt_in[32*a +: 32]   = $urandom;
        delta_in[32*a +: 32] = $urandom;
        sb.push_back('{cnt_in[32*a +: 32], AX_W'(a), 1'b0, 1'b0});
        sb.push_back('{delta_in[32*a +: 32], AX_W'(a), 1'b1, (NW == 2*AXES) && (a == AXES-1)});
      end
`ifdef SNAP_TIMESTAMP_EN
      sb.push_back('{snap_ts, AX_W'(0), 1'b1, 1'b1});
`endif
    end else begin
      cnt_in   = {$urandom, $urandom, $urandom, $urandom};
      delta_in = {$urandom, $urandom, $urandom, $urandom};
    end
    settle_flag = snapshot && aclr_n && !sclr;
    if (snapshot) begin
`ifdef SNAP_TIMESTAMP_EN
      snap_ts = ts_model;
`endif
      if (intv_en && last_snap >= 0) chk("snap_interval", 64'(cycle - last_snap), 64'(intv_exp));
      last_snap = cycle;
    end
    if (hold_vld && aclr_n)
      chk("hold_stable", {bus.rd_valid, bus.rd_last, bus.rd_sel, bus.rd_axis, bus.rd_data}, {1'b1, hold_word});
    hold_vld = 0;
    if (aclr_n && !sclr && bus.rd_valid) begin
      if (bus.rd_ready) begin
        if (sb.size() == 0) chk("extra_word_queue_depth", 64'(sb.size()), 64'd1);
        else begin
          w = sb.pop_front();
          chk($sformatf("frame_word%0d", widx), {bus.rd_last, bus.rd_sel, bus.rd_axis, bus.rd_data},
              {w.last, w.sel, w.axis, w.data});
          pops++;
          if (bus.rd_last) begin widx = 0; frames_done++; end
          else widx++;
        end
      end else begin
        hold_vld  = 1;
        hold_word = {bus.rd_last, bus.rd_sel, bus.rd_axis, bus.rd_data};
      end
    end
    if (!aclr_n || sclr) begin
      sb.delete(); widx = 0; settle_flag = 0; hold_vld = 0;
    end
`ifdef SNAP_TIMESTAMP_EN
    ts_model = (!aclr_n || sclr) ? 32'd0 : ts_model + 32'd1;
`endif
    @(negedge clk);
    cycle++;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (sb.size() != 0 || bus.rd_valid); i++) cyc();
    chk("drain", {sb.size() != 0, bus.rd_valid}, 64'd0);
  endtask

  task automatic pulse_sclr();
    sclr = 1'b1; cyc(); sclr = 1'b0;
    chk("sclr_clear", outs(), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd;
    bit busy_ack;
    aclr_n = 0; sclr = 0; run = 0; period = '0; step_busy = '0; cnt_in = '0; delta_in = '0;
    bus.wr_req = 0; bus.wr_axis = '0; bus.wr_addr = 0; bus.wr_be = '0; bus.wr_data = '0; bus.rd_ready = 0;
    vec[0] = '{2'd0, 1'b0, 2'b11, 16'hA5A5, 4'b0000, 4'b0001};
    vec[1] = '{2'd2, 1'b1, 2'b01, 16'h00FF, 4'b1011, 4'b0100};
    vec[2] = '{2'd3, 1'b1, 2'b10, 16'hFF00, 4'b0111, 4'b1000};
    vec[3] = '{2'd1, 1'b0, 2'b00, 16'h1357, 4'b0000, 4'b0000};
    vec[4] = '{2'd1, 1'b1, 2'b11, 16'hFFFF, 4'b1101, 4'b0010};

    @(negedge clk);
    cyc(); cyc();
    chk("reset_outputs", outs(), 64'd0);
    aclr_n = 1;
    cyc(); cyc();
    chk("idle_after_reset", outs(), 64'd0);

    // Periodic frames with an always-ready sink
    period = PERIOD_W'(P1); bus.rd_ready = 1;
    intv_en = 1; intv_exp = P1 + 1; last_snap = -1; frames_done = 0; pops = 0;
    run = 1;
    for (int i = 0; i < 6 * (P1 + 1) && frames_done < 3; i++) cyc();
    chk("t1_frames", 64'(frames_done), 64'd3);
    chk("t1_words", 64'(pops), 64'(3 * NW));
    chk("t1_queue_empty", 64'(sb.size()), 64'd0);
    run = 0; intv_en = 0;
    drain(40);

    // Stalled sink with fast ticks: hold, overrun, sticky until sclr
    pulse_sclr();
    period = 16'd3; bus.rd_ready = 0; run = 1;
    for (int i = 0; i < 20 && !bus.rd_valid; i++) cyc();
    chk("t2_valid_up", bus.rd_valid, 64'd1);
    repeat (20) cyc();
    chk("t2_overrun_set", overrun, 64'd1);
    chk("t2_valid_held", bus.rd_valid, 64'd1);
    bus.rd_ready = 1; run = 0;
    drain(40);
    chk("t2_overrun_sticky", overrun, 64'd1);
    pulse_sclr();

    // Write arbitration vector table, FSM idle
    foreach (vec[k]) begin
      bus.wr_axis = vec[k].axis; bus.wr_addr = vec[k].addr; bus.wr_be = vec[k].be;
      bus.wr_data = vec[k].data; step_busy = vec[k].busy; bus.wr_req = 1;
      cyc();
      chk($sformatf("wvec%0d_grant", k), {bus.wr_ack, cnt_write, cnt_addr, cnt_be, cnt_wrdata},
          {1'b1, vec[k].exp_write, vec[k].addr, vec[k].be, vec[k].data});
      cyc();
      chk($sformatf("wvec%0d_single", k), {bus.wr_ack, cnt_write}, 64'd0);
      bus.wr_req = 0; step_busy = '0;
      cyc();
    end

    // Busy target channel holds off the grant
    bus.wr_axis = 2'd2; bus.wr_addr = 1; bus.wr_be = 2'b11; bus.wr_data = 16'h1234;
    step_busy = 4'b0100; bus.wr_req = 1; busy_ack = 0;
    repeat (10) begin
      cyc();
      if (bus.wr_ack || cnt_write != 0) busy_ack = 1;
    end
    chk("t3_no_ack_busy", busy_ack, 64'd0);
    step_busy = '0;
    cyc();
    chk("t3_grant", {bus.wr_ack, cnt_write, cnt_addr, cnt_be, cnt_wrdata}, {1'b1, 4'b0100, 1'b1, 2'b11, 16'h1234});
    bus.wr_req = 0;
    cyc();
    chk("t3_ack_once", {bus.wr_ack, cnt_write}, 64'd0);

    // Tick and write eligibility in the same cycle
    period = '0; bus.rd_ready = 1;
    bus.wr_axis = 2'd1; bus.wr_addr = 0; bus.wr_be = 2'b11; bus.wr_data = 16'hBEEF; bus.wr_req = 1;
    run = 1;
    cyc();
    chk("t4_snap_first", {snapshot, bus.wr_ack}, 64'b10);
    cyc();
    chk("t4_settle_wait", {bus.rd_valid, bus.wr_ack}, 64'b00);
    cyc();
    chk("t4_send_wait", {bus.rd_valid, bus.wr_ack}, 64'b10);
    cyc();
    chk("t4_grant_in_send", {bus.rd_valid, bus.wr_ack, cnt_write, cnt_wrdata}, {1'b1, 1'b1, 4'b0010, 16'hBEEF});
    run = 0; bus.wr_req = 0;
    drain(40);
    pulse_sclr();

    // Asynchronous reset in the middle of a frame
    period = PERIOD_W'(P1); bus.rd_ready = 1; run = 1;
    for (int i = 0; i < 3 * (P1 + 1) && !(bus.rd_valid && widx == 3); i++) cyc();
    chk("t5_at_word3", {bus.rd_valid, 8'(widx)}, {1'b1, 8'd3});
    aclr_n = 0;
    #1;
    chk("t5_async_clear", outs(), 64'd0);
    cyc(); cyc();
    aclr_n = 1;
    fd = frames_done;
    for (int i = 0; i < 3 * (P1 + 1) && frames_done == fd; i++) cyc();
    chk("t5_frame_after_reset", 64'(frames_done - fd), 64'd1);
    run = 0;
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
